// File: rtl/dmem_responder.sv
// Data-memory responder: the memory side of the load/store interface.
// It takes one request at a time, waits WAIT cycles, then performs the access.
// It returns a one-cycle response and flags misaligned or out-of-range accesses.
module dmem_responder #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned WAIT  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic        req_byte,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned IdxW = $clog2(DEPTH);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, byte_q;
  logic [31:0] addr_q, wdata_q;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem [DEPTH];

  logic            req_accept;
  logic            access;
  logic            acc_err;
  logic            mem_we;
  logic [IdxW-1:0] idx;
  logic [1:0]      lane;
  logic [31:0]     cur_word;
  logic [7:0]      lane_byte;
  logic [31:0]     new_word;

  assign idx      = addr_q[IdxW+1:2];
  assign lane     = addr_q[1:0];
  assign cur_word = mem[idx];
  // Any nonzero address bit above the array range is out of range as well.
  assign acc_err  = (!byte_q && (lane != 2'd0)) || (addr_q[31:2] >= 30'(DEPTH));

  assign req_accept = (state_q == StIdle) && req_valid;
  assign mem_we     = access && we_q && !acc_err;

  assign req_ready  = (state_q == StIdle);
  assign resp_valid = (state_q == StResp);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  // Lane select for byte loads and lane merge for byte stores (little-endian).
  always_comb begin
    lane_byte = 8'h00;
    new_word  = byte_q ? cur_word : wdata_q;
    unique case (lane)
      2'd0: begin
        lane_byte = cur_word[7:0];
        if (byte_q) new_word[7:0] = wdata_q[7:0];
      end
      2'd1: begin
        lane_byte = cur_word[15:8];
        if (byte_q) new_word[15:8] = wdata_q[7:0];
      end
      2'd2: begin
        lane_byte = cur_word[23:16];
        if (byte_q) new_word[23:16] = wdata_q[7:0];
      end
      2'd3: begin
        lane_byte = cur_word[31:24];
        if (byte_q) new_word[31:24] = wdata_q[7:0];
      end
      default: ;
    endcase
  end

  // Next-state logic: accept, count down wait states, then access and respond.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    access  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          state_d = StBusy;
          cnt_d   = 4'(WAIT);
        end
      end
      StBusy: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          access  = 1'b1;
          state_d = StResp;
          err_d   = acc_err;
          rdata_d = 32'h0;
          if (!acc_err && !we_q) begin
            rdata_d = byte_q ? {24'h0, lane_byte} : cur_word;
          end
        end
      end
      StResp: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Control and response registers; reset discards any in-flight request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      byte_q  <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (req_accept) begin
        we_q    <= req_we;
        byte_q  <= req_byte;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
    end
  end

  // Memory array write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[idx] <= new_word;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed vector table on a WAIT=2
// instance plus sequences for mid-access reset and back-to-back WAIT=0 issue.
module tb_dmem_responder;

  logic clk = 1'b0;
  logic reset = 1'b0;

  // WAIT=2 instance
  logic        req_valid = 1'b0, req_we = 1'b0, req_byte = 1'b0;
  logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;

  // WAIT=0 instance
  logic        v0 = 1'b0, we0 = 1'b0, by0 = 1'b0;
  logic [31:0] addr0 = 32'h0, wd0 = 32'h0;
  logic        rdy0, rv0, er0;
  logic [31:0] rd0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(64), .WAIT(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_byte   (req_byte),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  dmem_responder #(.DEPTH(64), .WAIT(0)) dut0 (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (v0),
    .req_ready  (rdy0),
    .req_we     (we0),
    .req_byte   (by0),
    .req_addr   (addr0),
    .req_wdata  (wd0),
    .resp_valid (rv0),
    .resp_rdata (rd0),
    .resp_err   (er0)
  );

  typedef struct {
    logic        we;
    logic        byt;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One request on the WAIT=2 instance; inputs are scrambled after accept.
  task automatic do_req(input int id, input logic we, input logic byt, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rdata,
                        input logic exp_err);
    int lat;
    @(negedge clk);
    check($sformatf("v%0d ready_idle", id), 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_byte  = byt;
    req_addr  = addr;
    req_wdata = wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we    = ~we;
    req_byte  = ~byt;
    req_addr  = addr ^ 32'h0000_0014;
    req_wdata = ~wdata;
    check($sformatf("v%0d ready_busy", id), 32'(req_ready), 32'd0);
    lat = 0;
    while (lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (resp_valid) break;
    end
    check($sformatf("v%0d latency", id), 32'(lat), 32'd3);
    check($sformatf("v%0d rdata", id), resp_rdata, exp_rdata);
    check($sformatf("v%0d err", id), 32'(resp_err), 32'(exp_err));
    check($sformatf("v%0d ready_resp", id), 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    check($sformatf("v%0d pulse_width", id), 32'(resp_valid), 32'd0);
    check($sformatf("v%0d rdata_hold", id), resp_rdata, exp_rdata);
    check($sformatf("v%0d err_hold", id), 32'(resp_err), 32'(exp_err));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic saw;
    vecs[0]  = '{1'b1, 1'b0, 32'h10,       32'hDEADBEEF, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 1'b0, 32'h10,       32'h0,        32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 32'h10,       32'h11223344, 32'h0,        1'b0};
    vecs[3]  = '{1'b1, 1'b1, 32'h11,       32'h123456AA, 32'h0,        1'b0};
    vecs[4]  = '{1'b0, 1'b0, 32'h10,       32'h0,        32'h1122AA44, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 32'h13,       32'h0,        32'h00000011, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 32'h10,       32'h0,        32'h00000044, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 32'h12,       32'h0,        32'h0,        1'b1};
    vecs[8]  = '{1'b1, 1'b0, 32'h12,       32'h55555555, 32'h0,        1'b1};
    vecs[9]  = '{1'b0, 1'b0, 32'h100,      32'h0,        32'h0,        1'b1};
    vecs[10] = '{1'b1, 1'b0, 32'h80000010, 32'hCAFEF00D, 32'h0,        1'b1};
    vecs[11] = '{1'b1, 1'b1, 32'h101,      32'h000000EE, 32'h0,        1'b1};
    vecs[12] = '{1'b0, 1'b0, 32'h10,       32'h0,        32'h1122AA44, 1'b0};
    vecs[13] = '{1'b1, 1'b0, 32'h20,       32'h0,        32'h0,        1'b0};

    // Reset values
    #12;
    check("rst resp_valid", 32'(resp_valid), 32'd0);
    check("rst resp_rdata", resp_rdata, 32'h0);
    check("rst resp_err", 32'(resp_err), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst req_ready", 32'(req_ready), 32'd1);

    for (int i = 0; i < 14; i++) begin
      do_req(i, vecs[i].we, vecs[i].byt, vecs[i].addr, vecs[i].wdata,
             vecs[i].exp_rdata, vecs[i].exp_err);
    end

    // Leave a nonzero held response so the reset clear is observable.
    do_req(20, 1'b0, 1'b0, 32'h10, 32'h0, 32'h1122AA44, 1'b0);

    // Reset while a store to 0x20 is waiting in BUSY.
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_byte  = 1'b0;
    req_addr  = 32'h20;
    req_wdata = 32'h12345678;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("midrst busy", 32'(req_ready), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst resp_valid", 32'(resp_valid), 32'd0);
    check("midrst resp_rdata", resp_rdata, 32'h0);
    check("midrst resp_err", 32'(resp_err), 32'd0);
    saw = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (resp_valid) saw = 1'b1;
    end
    check("midrst no_resp", 32'(saw), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst ready_after", 32'(req_ready), 32'd1);
    do_req(30, 1'b0, 1'b0, 32'h20, 32'h0, 32'h0, 1'b0);

    // WAIT=0: req_valid held high, stores alternating between 0x0 and 0x4.
    @(negedge clk);
    v0    = 1'b1;
    we0   = 1'b1;
    by0   = 1'b0;
    addr0 = 32'h0;
    wd0   = 32'h1;
    for (int i = 0; i < 15; i++) begin
      #1;
      check($sformatf("w0 c%0d ready", i), 32'(rdy0), 32'((i % 3) == 0));
      check($sformatf("w0 c%0d resp_valid", i), 32'(rv0), 32'((i % 3) == 2));
      if (rv0) check($sformatf("w0 c%0d err", i), 32'(er0), 32'd0);
      @(posedge clk);
      if ((i % 3) == 0) begin
        #1;
        addr0 = addr0 ^ 32'h4;
        wd0   = wd0 + 32'd1;
      end
      @(negedge clk);
    end
    v0 = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
